// File: rtl/hilo_unit_pkg.sv
// Shared CPU definitions: decoded op encoding, data word and HI/LO pair,
// plus the multiply engine's state type.
package cpu_defs;
  typedef logic [31:0] Word_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_MULT, OP_MULTU
  } Oper_t;

  typedef struct packed {
    Word_t hi;
    Word_t lo;
  } HiLo_t;

  localparam int MUL_CYCLES = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL_RUN, ST_MUL_DONE} MulState_t;

  // 0x80000000 maps onto itself, which read unsigned is the 2^31 magnitude.
  function automatic Word_t mag32(Word_t v, logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_unit_if.sv
// Op issue / read-data bundle between the decoder side and hilo_unit.
interface hilo_unit_if;
  import cpu_defs::*;
  Oper_t op;
  logic  op_valid;
  logic  op_ready;
  Word_t reg1;
  Word_t reg2;
  Word_t result;
  logic  result_valid;

  modport master (output op, op_valid, reg1, reg2,
                  input  op_ready, result, result_valid);
  modport slave  (input  op, op_valid, reg1, reg2,
                  output op_ready, result, result_valid);
endinterface

// File: rtl/hilo_unit_mul_iter.sv
// Radix-2 shift-add multiplier on operand magnitudes; sign applied to the
// final 64-bit product. abort drops any in-flight multiply.
module mul_iter
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_op_i,
  input  Word_t       a_i,
  input  Word_t       b_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);
  localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

  MulState_t   state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  Word_t       mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        mcand_d  = {32'd0, mag32(a_i, signed_op_i)};
        mplier_d = mag32(b_i, signed_op_i);
        neg_d    = signed_op_i & (a_i[31] ^ b_i[31]);
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ST_MUL_RUN;
      end
      ST_MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = ST_MUL_DONE;
      end
      ST_MUL_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (abort_i && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_MUL_DONE);
  assign product_o = neg_q ? -acc_q : acc_q;
endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO unit: architectural HI/LO, MFxx/MTxx and an iterative
// multiply that stalls issue via op_ready until the product is written.
module hilo_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  hilo_unit_if.slave  bus,
  output Word_t       hi_out,
  output Word_t       lo_out
);
  HiLo_t hilo_q, hilo_d;
  Word_t result_q, result_d;
  logic  rv_q, rv_d;

  logic        accept, mul_start, mul_busy, mul_done;
  logic [63:0] mul_product;

  assign bus.op_ready = ~mul_busy;
  assign accept       = bus.op_valid & bus.op_ready & ~flush;
  assign mul_start    = accept & (bus.op == OP_MULT || bus.op == OP_MULTU);

  mul_iter u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (mul_start),
    .signed_op_i(bus.op == OP_MULT),
    .a_i        (bus.reg1),
    .b_i        (bus.reg2),
    .abort_i    (flush),
    .busy_o     (mul_busy),
    .done_o     (mul_done),
    .product_o  (mul_product)
  );

  always_comb begin
    hilo_d   = hilo_q;
    result_d = result_q;
    rv_d     = 1'b0;
    if (accept) begin
      unique case (bus.op)
        OP_MTHI: hilo_d.hi = bus.reg1;
        OP_MTLO: hilo_d.lo = bus.reg1;
        OP_MFHI: begin result_d = hilo_q.hi; rv_d = 1'b1; end
        OP_MFLO: begin result_d = hilo_q.lo; rv_d = 1'b1; end
        default: ;
      endcase
    end
    // A flush landing on the completion cycle discards the product.
    if (mul_done && !flush) hilo_d = mul_product;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hilo_q   <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      hilo_q   <= hilo_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign hi_out           = hilo_q.hi;
  assign lo_out           = hilo_q.lo;
endmodule
